// File: rtl/fader_pkg.sv
// Shared widths and types for the fader output monitor.
package fader_pkg;
    localparam int SAMPLE_W  = 16;
    localparam int T_INDEX_W = 25;
    localparam int POWER_W   = 32;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } sample_t;

    typedef logic [POWER_W-1:0]   power_t;
    typedef logic [T_INDEX_W-1:0] t_index_t;

    typedef enum logic {IDLE, BUSY} hs_state_t;
endpackage

// File: rtl/fader_monitor_if.sv
// Fader-side handshake plus block-result port of the monitor.
interface fader_monitor_if;
    import fader_pkg::*;

    logic                       start;
    t_index_t                   t_index;
    logic                       dv_out;
    logic signed [SAMPLE_W-1:0] Zc_real;
    logic signed [SAMPLE_W-1:0] Zc_imag;

    logic                       blk_valid;
    logic                       blk_ready;
    power_t                     blk_mean;
    power_t                     blk_min;
    power_t                     blk_max;
    t_index_t                   blk_t_index;
    logic [15:0]                drop_count;
    logic                       err_timeout;
    logic                       err_overlap;
    logic                       err_spurious;

    modport master (
        output start, t_index, dv_out, Zc_real, Zc_imag, blk_ready,
        input  blk_valid, blk_mean, blk_min, blk_max, blk_t_index,
               drop_count, err_timeout, err_overlap, err_spurious
    );

    modport slave (
        input  start, t_index, dv_out, Zc_real, Zc_imag, blk_ready,
        output blk_valid, blk_mean, blk_min, blk_max, blk_t_index,
               drop_count, err_timeout, err_overlap, err_spurious
    );
endinterface

// File: rtl/fader_power.sv
// Three-stage |Z|^2 pipeline (input register, squares, sum) with a tag riding alongside.
module fader_power
    import fader_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     valid_i,
    input  sample_t  sample_i,
    input  t_index_t tag_i,
    output logic     valid_o,
    output power_t   power_o,
    output t_index_t tag_o
);
    logic [2:0]                valid_q;
    sample_t                   sample_q;
    logic signed [POWER_W-1:0] sq_re_q, sq_im_q;
    power_t                    power_q;
    t_index_t                  tag1_q, tag2_q, tag3_q;
    logic signed [POWER_W-1:0] re_ext, im_ext;

    assign re_ext = POWER_W'($signed(sample_q.re));
    assign im_ext = POWER_W'($signed(sample_q.im));

    // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= {valid_q[1:0], valid_i};
    end

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        sample_q <= sample_i;
        tag1_q   <= tag_i;
        sq_re_q  <= re_ext * re_ext;
        sq_im_q  <= im_ext * im_ext;
        tag2_q   <= tag1_q;
        power_q  <= power_t'(sq_re_q) + power_t'(sq_im_q);
        tag3_q   <= tag2_q;
    end

    assign valid_o = valid_q[2];
    assign power_o = power_q;
    assign tag_o   = tag3_q;
endmodule

// File: rtl/fader_monitor.sv
// Fader consumer: start/dv_out protocol checker with watchdog, plus block power statistics.
module fader_monitor
    import fader_pkg::*;
#(
    parameter int LOG2_AVG = 4,
    parameter int TIMEOUT  = 1023
)
(
    input logic            clk,
    input logic            reset,
    fader_monitor_if.slave bus
);
    localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int ACC_W   = POWER_W + LOG2_AVG;
    localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT);

    hs_state_t          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    t_index_t           pending_q, pending_d;
    logic               set_timeout, set_overlap, set_spurious;
    logic               err_timeout_q, err_overlap_q, err_spurious_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            pending_q      <= '0;
            err_timeout_q  <= 1'b0;
            err_overlap_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            pending_q      <= pending_d;
            err_timeout_q  <= err_timeout_q  | set_timeout;
            err_overlap_q  <= err_overlap_q  | set_overlap;
            err_spurious_q <= err_spurious_q | set_spurious;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        set_timeout  = 1'b0;
        set_overlap  = 1'b0;
        set_spurious = 1'b0;
        unique case (state_q)
            IDLE: begin
                set_spurious = bus.dv_out;
                if (bus.start) begin
                    state_d   = BUSY;
                    pending_d = bus.t_index;
                    timer_d   = TIMER_LOAD;
                end
            end
            BUSY: begin
                if (bus.start) begin
                    pending_d   = bus.t_index;
                    timer_d     = TIMER_LOAD;
                    set_overlap = !bus.dv_out;
                end else if (bus.dv_out) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d     = IDLE;
                    set_timeout = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every dv_out is measured, including spurious ones; the tag is the last latched t_index.
    sample_t  sample_in;
    logic     p_valid;
    power_t   p;
    t_index_t p_tag;

    assign sample_in.re = bus.Zc_real;
    assign sample_in.im = bus.Zc_imag;

    fader_power u_power (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (bus.dv_out),
        .sample_i (sample_in),
        .tag_i    (pending_q),
        .valid_o  (p_valid),
        .power_o  (p),
        .tag_o    (p_tag)
    );

    logic [CNT_W-1:0] count_q;
    logic [ACC_W-1:0] sum_q, sum_new;
    power_t           min_q, max_q, min_new, max_new, mean_new;
    logic             first, last, blk_done;

    always_comb begin
        first    = (count_q == '0);
        last     = (count_q == LAST_CNT);
        sum_new  = first ? ACC_W'(p) : sum_q + ACC_W'(p);
        min_new  = (first || p < min_q) ? p : min_q;
        max_new  = (first || p > max_q) ? p : max_q;
        mean_new = POWER_W'(sum_new >> LOG2_AVG);
        blk_done = p_valid && last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else if (p_valid) begin
            count_q <= last ? '0 : count_q + CNT_W'(1);
            sum_q   <= sum_new;
            min_q   <= min_new;
            max_q   <= max_new;
        end
    end

    logic        blk_valid_q, handshake;
    power_t      blk_mean_q, blk_min_q, blk_max_q;
    t_index_t    blk_tag_q;
    logic [15:0] drop_q;

    assign handshake = blk_valid_q && bus.blk_ready;

    // A completing block may replace the held one only when the slot is empty or being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_valid_q <= 1'b0;
            blk_mean_q  <= '0;
            blk_min_q   <= '0;
            blk_max_q   <= '0;
            blk_tag_q   <= '0;
            drop_q      <= '0;
        end else if (blk_done && (!blk_valid_q || handshake)) begin
            blk_valid_q <= 1'b1;
            blk_mean_q  <= mean_new;
            blk_min_q   <= min_new;
            blk_max_q   <= max_new;
            blk_tag_q   <= p_tag;
        end else begin
            if (handshake) blk_valid_q <= 1'b0;
            if (blk_done && drop_q != '1) drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.blk_valid    = blk_valid_q;
    assign bus.blk_mean     = blk_mean_q;
    assign bus.blk_min      = blk_min_q;
    assign bus.blk_max      = blk_max_q;
    assign bus.blk_t_index  = blk_tag_q;
    assign bus.drop_count   = drop_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_overlap  = err_overlap_q;
    assign bus.err_spurious = err_spurious_q;
endmodule

// File: tb/tb_fader_monitor.sv
// Directed bench for fader_monitor with LOG2_AVG=2 and TIMEOUT=1023.
module tb_fader_monitor;
    import fader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    fader_monitor_if bus();

    fader_monitor #(.LOG2_AVG(2), .TIMEOUT(1023)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic [24:0] t);
        bus.start   = 1'b1;
        bus.t_index = t;
        tick();
        bus.start   = 1'b0;
        bus.dv_out  = 1'b1;
        bus.Zc_real = re;
        bus.Zc_imag = im;
        tick();
        bus.dv_out  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.blk_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.blk_valid), 32'd1);
    endtask

    task automatic check_block(input string tag, input logic [31:0] mean, input logic [31:0] mn,
                               input logic [31:0] mx, input logic [31:0] t);
        check({tag, "_mean"}, bus.blk_mean, mean);
        check({tag, "_min"},  bus.blk_min,  mn);
        check({tag, "_max"},  bus.blk_max,  mx);
        check({tag, "_tidx"}, 32'(bus.blk_t_index), t);
    endtask

    task automatic check_errors(input string tag, input logic to, input logic ov, input logic sp);
        check({tag, "_err_timeout"},  32'(bus.err_timeout),  32'(to));
        check({tag, "_err_overlap"},  32'(bus.err_overlap),  32'(ov));
        check({tag, "_err_spurious"}, 32'(bus.err_spurious), 32'(sp));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(bus.blk_valid), 32'd0);
        check_block(tag, 32'd0, 32'd0, 32'd0, 32'd0);
        check({tag, "_drop"}, 32'(bus.drop_count), 32'd0);
        check_errors(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200 us");
        $fatal(1, "global timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.t_index   = '0;
        bus.dv_out    = 1'b0;
        bus.Zc_real   = '0;
        bus.Zc_imag   = '0;
        bus.blk_ready = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        // Basic block of four (3,4) samples, |Z|^2 = 25; blk_valid 4 cycles after the last dv_out
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'd3, 16'd4, 25'(10 + i));
        tick();
        tick();
        check("t1_lat_early", 32'(bus.blk_valid), 32'd0);
        tick();
        check("t1_lat", 32'(bus.blk_valid), 32'd1);
        check_block("t1", 32'd25, 32'd25, 32'd25, 32'd13);
        check_errors("t1", 1'b0, 1'b0, 1'b0);
        tick();
        check("t1_consumed", 32'(bus.blk_valid), 32'd0);

        // Extremes: p = 2^31, 0, 1, 1 -> sum 2^31+2, mean 0x20000000
        send(16'h8000, 16'h8000, 25'd20);
        send(16'h0000, 16'h0000, 25'd21);
        send(16'h0001, 16'h0000, 25'd22);
        send(16'h0000, 16'hFFFF, 25'd23);
        wait_valid("t2_valid");
        check_block("t2", 32'h2000_0000, 32'd0, 32'h8000_0000, 32'd23);
        tick();

        // Backpressure: block A (p = 1,4,9,16 -> mean 7) held, blocks B and C dropped
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(i + 1), 16'd0, 25'(30 + i));
        for (int i = 0; i < 4; i++) send(16'd5, 16'd5, 25'(34 + i));
        for (int i = 0; i < 4; i++) send(16'd6, 16'd0, 25'(38 + i));
        repeat (5) tick();
        check("t4_held_valid", 32'(bus.blk_valid), 32'd1);
        check_block("t4_held", 32'd7, 32'd1, 32'd16, 32'd33);
        check("t4_drop", 32'(bus.drop_count), 32'd2);
        bus.blk_ready = 1'b1;
        check_block("t4_deliver", 32'd7, 32'd1, 32'd16, 32'd33);
        tick();
        check("t4_released", 32'(bus.blk_valid), 32'd0);
        check("t4_drop_kept", 32'(bus.drop_count), 32'd2);

        // Watchdog: start at edge E0, err_timeout visible after edge E0+1024
        bus.start   = 1'b1;
        bus.t_index = 25'd50;
        tick();
        bus.start = 1'b0;
        repeat (1023) tick();
        check("t3_before", 32'(bus.err_timeout), 32'd0);
        tick();
        check("t3_fire", 32'(bus.err_timeout), 32'd1);

        // Back-to-back dv_out, with start and dv_out together while BUSY (no overlap error)
        bus.start   = 1'b1;
        bus.t_index = 25'd40;
        tick();
        bus.dv_out  = 1'b1;
        bus.Zc_real = 16'd0;
        bus.Zc_imag = 16'd2;
        for (int i = 1; i < 4; i++) begin
            bus.t_index = 25'(40 + i);
            tick();
        end
        bus.start = 1'b0;
        tick();
        bus.dv_out = 1'b0;
        wait_valid("t3_after_valid");
        check_block("t3_after", 32'd4, 32'd4, 32'd4, 32'd43);
        check_errors("t3_after", 1'b1, 1'b0, 1'b0);
        tick();

        // Protocol errors, then reset with two samples of a block already taken
        bus.dv_out  = 1'b1;
        bus.Zc_real = 16'd100;
        bus.Zc_imag = 16'd0;
        tick();
        bus.dv_out = 1'b0;
        check_errors("t5_spurious", 1'b1, 1'b0, 1'b1);
        bus.start   = 1'b1;
        bus.t_index = 25'd60;
        tick();
        bus.t_index = 25'd61;
        tick();
        bus.start = 1'b0;
        check_errors("t5_overlap", 1'b1, 1'b1, 1'b1);
        bus.dv_out = 1'b1;
        tick();
        bus.dv_out = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("t5_reset");
        for (int i = 0; i < 4; i++) send(16'd0, 16'd3, 25'(70 + i));
        wait_valid("t5_post_valid");
        check_block("t5_post", 32'd9, 32'd9, 32'd9, 32'd73);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
